// File: rtl/skid_pipe_stage_pkg.sv
// Shared types and constants for the skid pipeline stage.
// The package is pipe_stage_pkg; compile it before the other design files.
package pipe_stage_pkg;

  localparam int STALL_CNT_W    = 16;
  localparam int DEFAULT_LENGTH = 151;

  // The state is the occupancy: EMPTY = 0 entries, BUSY = 1, FULL = 2.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/skid_data_reg.sv
// Load-enabled payload register with asynchronous active-low clear to zero.
// It is used for both the main entry and the skid entry of skid_pipe_stage.
module skid_data_reg #(
  parameter int W = 151
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/skid_pipe_stage.sv
// Two-entry skid buffer pipeline stage. in_ready is decoded from registered state only.
// Define PIPE_STAGE_STALL_CNT_EN to build the saturating upstream stall counter.
module skid_pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int LENGTH = DEFAULT_LENGTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   softReset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LENGTH-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LENGTH-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stallCount
);

  state_e            state_q, state_d;
  logic              push_s, pop_s;
  logic              main_load_s, main_from_skid_s, skid_load_s;
  logic [LENGTH-1:0] main_d, main_q, skid_q;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign main_d    = main_from_skid_s ? skid_q : in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push_s) begin
          main_load_s = 1'b1;
          state_d     = BUSY;
        end else begin
          state_d = EMPTY;
        end
      end
      BUSY: begin
        if (push_s && pop_s) begin
          main_load_s = 1'b1;
          state_d     = BUSY;
        end else if (push_s) begin
          skid_load_s = 1'b1;
          state_d     = FULL;
        end else if (pop_s) begin
          state_d = EMPTY;
        end else begin
          state_d = BUSY;
        end
      end
      FULL: begin
        if (pop_s) begin
          main_load_s      = 1'b1;
          main_from_skid_s = 1'b1;
          state_d          = BUSY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Flush drops occupancy only; payload registers keep their contents.
    if (softReset) begin
      state_d     = EMPTY;
      main_load_s = 1'b0;
      skid_load_s = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  skid_data_reg #(.W(LENGTH)) u_main (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (main_load_s),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  skid_data_reg #(.W(LENGTH)) u_skid (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (skid_load_s),
    .d_i    (in_data),
    .q_o    (skid_q)
  );

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (softReset) begin
      stall_cnt_q <= '0;
    end else if (in_valid && !in_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stallCount = stall_cnt_q;
`else
  assign stallCount = '0;
`endif

endmodule

// File: tb/tb_skid_pipe_stage.sv
// Directed and randomized self-checking bench for skid_pipe_stage.
// Stall-count saturation checks apply only when PIPE_STAGE_STALL_CNT_EN is defined.
module tb_skid_pipe_stage;

  localparam int L = 151;

  logic         clk = 1'b0;
  logic         reset;
  logic         softReset;
  logic         in_valid;
  logic         in_ready;
  logic [L-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [L-1:0] out_data;
  logic [15:0]  stallCount;

  int total = 0;
  int bad   = 0;

  skid_pipe_stage #(.LENGTH(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .softReset  (softReset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stallCount (stallCount)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; softReset = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = L'(8'hAA);
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (stallCount !== 16'h0000) begin bad++; $display("FAIL rst_stall got=%h exp=0", stallCount); end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL idle_out_data got=%h exp=0", out_data); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = L'(8'h55);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_loaded got=%b exp=1", out_valid); end
    #2 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL ar_out_data got=%h exp=0", out_data); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 8) begin
        total++; if (out_valid !== 1'b1 || out_data !== L'(i)) begin
          bad++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, i);
        end
      end
      if (i == 9) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
      in_valid = (i < 8);
      in_data  = L'(i + 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = L'(8'hA1);
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data !== L'(8'hA1) || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_busy got=%b/%h/%b exp=1/a1/1", out_valid, out_data, in_ready);
    end
    in_data = L'(8'hB2);
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_data !== L'(8'hA1)) begin
      bad++; $display("FAIL bp_full got=%b/%h exp=0/a1", in_ready, out_data);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== L'(8'hB2)) begin
      bad++; $display("FAIL bp_second got=%b/%b/%h exp=1/1/b2", in_ready, out_valid, out_data);
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = L'(8'h11);
    @(negedge clk);
    in_data = L'(8'h22);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_full got=%b exp=0", in_ready); end
    softReset = 1'b1; in_data = L'(8'h33);
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL fl_empty got=%b/%b exp=0/1", out_valid, in_ready);
    end
    total++; if (stallCount !== 16'h0000) begin bad++; $display("FAIL fl_stall got=%h exp=0", stallCount); end
    softReset = 1'b0; in_data = L'(8'h44); out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data !== L'(8'h44)) begin
      bad++; $display("FAIL fl_next got=%b/%h exp=1/44", out_valid, out_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_stall_count();
    in_valid = 1'b1; in_data = L'(8'h66);
    repeat (2) @(negedge clk);
    repeat (5) @(negedge clk);
`ifdef PIPE_STAGE_STALL_CNT_EN
    total++; if (stallCount !== 16'd5) begin bad++; $display("FAIL stall5 got=%h exp=0005", stallCount); end
    repeat (65529) @(negedge clk);
    total++; if (stallCount !== 16'hFFFE) begin bad++; $display("FAIL stall_fffe got=%h exp=fffe", stallCount); end
    repeat (3) @(negedge clk);
    total++; if (stallCount !== 16'hFFFF) begin bad++; $display("FAIL stall_sat got=%h exp=ffff", stallCount); end
`else
    total++; if (stallCount !== 16'h0000) begin bad++; $display("FAIL stall_off got=%h exp=0", stallCount); end
`endif
    total++; if (out_data !== L'(8'h66) || in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_hold got=%h/%b exp=66/0", out_data, in_ready);
    end
    in_valid = 1'b0; softReset = 1'b1;
    @(negedge clk);
    softReset = 1'b0;
    total++; if (stallCount !== 16'h0000 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_clear got=%h/%b exp=0/0", stallCount, out_valid);
    end
  endtask

  task automatic test_random();
    logic [L-1:0] q[$];
    logic [159:0] rnd;
    bit           pu, po;
    int           errs = 0;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
          (q.size() > 0 && out_data !== q[0])) begin
        bad++;
        if (errs < 10) $display("FAIL rand[%0d] got v=%b r=%b d=%h exp_n=%0d", c, out_valid, in_ready, out_data, q.size());
        errs++;
      end
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_data = rnd[L-1:0];
      po = (q.size() > 0) && out_ready;
      pu = in_valid && (q.size() < 2);
      if (po) void'(q.pop_front());
      if (pu) q.push_back(in_data);
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; softReset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_async_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_stall_count();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skid_pipe_stage.md
SKID_PIPE_STAGE -- requirements
Module: skid_pipe_stage

Interface
REQ-001 The block SHALL have parameter LENGTH, default 151, giving the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port softReset, input, 1, synchronous flush, active-high.
REQ-005 The block SHALL have port in_valid, input, 1, upstream has payload.
REQ-006 The block SHALL have port in_ready, output, 1, stage accepts payload this cycle.
REQ-007 The block SHALL have port in_data, input, LENGTH, upstream payload.
REQ-008 The block SHALL have port out_valid, output, 1, stage presents payload.
REQ-009 The block SHALL have port out_ready, input, 1, downstream accepts payload.
REQ-010 The block SHALL have port out_data, output, LENGTH, presented payload.
REQ-011 The block SHALL have port stallCount, output, 16, upstream stall-cycle counter.

Function
REQ-012 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-013 The block SHALL hold two LENGTH-wide registers, main and skid, and a state machine with states EMPTY, BUSY and FULL.
REQ-014 in_ready SHALL be a function of state only (state != FULL); it SHALL have no combinational path from out_ready.
REQ-015 out_valid SHALL equal (state != EMPTY); out_data SHALL equal main.
REQ-016 In EMPTY, a push SHALL load main from in_data and go to BUSY; otherwise the stage stays EMPTY.
REQ-017 In BUSY, push with pop SHALL load main from in_data and stay BUSY; push alone SHALL load skid and go to FULL; pop alone SHALL go to EMPTY; neither SHALL hold.
REQ-018 In FULL, pop SHALL copy skid to main and go to BUSY; no pop SHALL hold.
REQ-019 Latency SHALL be 1 cycle from push into EMPTY to out_valid; sustained throughput SHALL be 1 payload per cycle while out_ready stays high.
REQ-020 Payload order SHALL be preserved, with no payload lost or duplicated under any in_valid/out_ready pattern.
REQ-021 softReset SHALL force next state EMPTY, overriding any simultaneous push or pop; the main and skid contents SHALL be left unchanged.

Reset
REQ-022 While reset is low, state SHALL be EMPTY, main, skid and stallCount SHALL be 0, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-023 Pushes SHALL be ignored while reset is low.
REQ-024 Asserting reset mid-transfer SHALL discard both entries immediately, without waiting for a clock edge.

Configuration
REQ-025 With macro PIPE_STAGE_STALL_CNT_EN defined, stallCount SHALL increment by 1 on each cycle with in_valid && !in_ready, saturate at 16'hFFFF, and clear on softReset.
REQ-026 Without PIPE_STAGE_STALL_CNT_EN, stallCount SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-027 Package pipe_stage_pkg SHALL hold the state enum typedef (EMPTY, BUSY, FULL), STALL_CNT_W = 16 and DEFAULT_LENGTH = 151.
REQ-028 main and skid SHALL each be an instance of sub-module skid_data_reg, a LENGTH-wide load-enabled register with async active-low reset to 0.

Verification
REQ-029 Reset then idle: reset low 2 cycles, then high -> out_valid=0, in_ready=1, stallCount=0.
REQ-030 Streaming: out_ready=1 and push 8'h01..8'h08 on consecutive cycles -> out_data 8'h01..8'h08 on consecutive cycles, each 1 cycle after its push, in_ready always 1.
REQ-031 Backpressure: out_ready=0, push A then B -> FULL and in_ready=0; then out_ready=1 -> A, then B, in order, and in_ready back to 1 the cycle after A pops.
REQ-032 Flush: in FULL, softReset=1 together with in_valid=1 -> next cycle EMPTY, out_valid=0 and the pushed payload is not presented.
REQ-033 Stall count (macro on): hold FULL with in_valid=1 for 5 cycles -> stallCount=5; preload at 16'hFFFE and stall 3 cycles -> stallCount=16'hFFFF.
REQ-034 Random in_valid/out_ready for 10k cycles against a reference queue model -> zero mismatches, and in_ready never low unless state is FULL.
